// File: rtl/comb_eval_arbiter_if.sv
// Request/response bundle for comb_eval_arbiter. perf_grants exists only when
// CCL_ARB_PERF_EN is defined.
interface comb_eval_arbiter_if #(
   parameter int NREQ  = 4,
   parameter int ID_W  = 2,
   parameter int CNT_W = 16
);
   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0][3:0]  req_vec;
   logic [NREQ-1:0]       req_ready;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [ID_W-1:0]       rsp_id;
   logic [2:0]            rsp_xyz;
`ifdef CCL_ARB_PERF_EN
   logic [CNT_W-1:0]      perf_grants;

   modport master (output req_valid, req_vec, rsp_ready,
                   input  req_ready, rsp_valid, rsp_id, rsp_xyz, perf_grants);
   modport slave  (input  req_valid, req_vec, rsp_ready,
                   output req_ready, rsp_valid, rsp_id, rsp_xyz, perf_grants);
`else
   modport master (output req_valid, req_vec, rsp_ready,
                   input  req_ready, rsp_valid, rsp_id, rsp_xyz);
   modport slave  (input  req_valid, req_vec, rsp_ready,
                   output req_ready, rsp_valid, rsp_id, rsp_xyz);
`endif

   if (CNT_W < 1 || ID_W < 1 || NREQ < 2) begin : g_param_chk
      $error("comb_eval_arbiter_if: bad parameters");
   end
endinterface

// File: rtl/comb_eval_arbiter.sv
// Round-robin arbiter sharing one complex_comb_logic evaluator among NREQ requesters,
// with a registered response. CCL_ARB_PERF_EN adds the saturating perf_grants counter.
module comb_eval_arbiter #(
   parameter int NREQ  = 4,
   parameter int ID_W  = 2,
   parameter int CNT_W = 16
) (
   input  logic clk,
   input  logic rst_n,
   comb_eval_arbiter_if.slave bus
);

   if (NREQ < 2 || NREQ > 16 || ID_W != $clog2(NREQ) || CNT_W < 1) begin : g_param_chk
      $error("comb_eval_arbiter: bad parameters");
   end

   typedef enum logic {EMPTY, FULL} state_t;

   localparam logic [ID_W:0] NREQ_L = (ID_W+1)'(NREQ);

   // {a,b,c,d} -> {x,y,z}
   function automatic logic [2:0] eval_ccl(input logic [3:0] v);
      logic a, b, c, d;
      {a, b, c, d} = v;
      return {~(c & d), a & b & ~c, a ^ c};
   endfunction

   state_t           state;
   logic [ID_W-1:0]  rr_ptr;
   logic             rsp_valid;
   logic [ID_W-1:0]  rsp_id;
   logic [2:0]       rsp_xyz;

   logic             can_accept;
   logic [NREQ-1:0]  rot;
   logic             any_valid;
   logic [ID_W-1:0]  off;
   logic [ID_W:0]    sum;
   logic [ID_W-1:0]  gnt_idx;
   logic             grant;
   logic [3:0]       sel_vec;
   logic [2:0]       eval_xyz;

   // Rotate valids so rr_ptr sits at bit 0; the lowest set bit is then the winner.
   always_comb begin
      can_accept = (state == EMPTY) | bus.rsp_ready;
      rot        = (bus.req_valid >> rr_ptr) | (bus.req_valid << (NREQ - int'(rr_ptr)));
      any_valid  = 1'b0;
      off        = '0;
      for (int j = NREQ-1; j >= 0; j--) begin
         if (rot[j]) begin
            off       = ID_W'(j);
            any_valid = 1'b1;
         end
      end
      sum = {1'b0, rr_ptr} + {1'b0, off};
      if (sum >= NREQ_L) sum = sum - NREQ_L;
      gnt_idx = sum[ID_W-1:0];
      grant   = rst_n & can_accept & any_valid;
   end

   assign bus.req_ready = grant ? ({{(NREQ-1){1'b0}}, 1'b1} << gnt_idx) : '0;
   assign sel_vec       = bus.req_vec[gnt_idx];
   assign eval_xyz      = eval_ccl(sel_vec);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= EMPTY;
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_xyz   <= '0;
         rr_ptr    <= '0;
      end else begin
         if (grant) begin
            state     <= FULL;
            rsp_valid <= 1'b1;
            rsp_id    <= gnt_idx;
            rsp_xyz   <= eval_xyz;
            rr_ptr    <= (gnt_idx == ID_W'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
         end else begin
            case (state)
               EMPTY: ;
               FULL: begin
                  // Drained with nothing new: id/xyz keep their last values.
                  if (bus.rsp_ready) begin
                     state     <= EMPTY;
                     rsp_valid <= 1'b0;
                  end
               end
               default: begin
                  state     <= EMPTY;
                  rsp_valid <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.rsp_valid = rsp_valid;
   assign bus.rsp_id    = rsp_id;
   assign bus.rsp_xyz   = rsp_xyz;

`ifdef CCL_ARB_PERF_EN
   logic [CNT_W-1:0] perf_grants;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                       perf_grants <= '0;
      else if (grant && !(&perf_grants)) perf_grants <= perf_grants + 1'b1;
   end

   assign bus.perf_grants = perf_grants;
`endif

endmodule

// File: tb/tb_comb_eval_arbiter.sv
// Directed + randomized bench for comb_eval_arbiter against a queue-free
// behavioural model of the round-robin and response-register rules.
module tb_comb_eval_arbiter;
   localparam int NREQ  = 4;
   localparam int ID_W  = 2;
   localparam int CNT_W = 16;

   typedef logic [NREQ-1:0][3:0] vecs_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   comb_eval_arbiter_if #(.NREQ(NREQ), .ID_W(ID_W), .CNT_W(CNT_W)) bus ();
   comb_eval_arbiter #(.NREQ(NREQ), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus));

   int nvec = 0;
   int nerr = 0;

   // model state
   int m_full, m_ptr, m_id, m_xyz, m_cnt, last_g;

   logic [3:0] tbl_in  [5];
   logic [2:0] tbl_out [5];

   function automatic int ref_xyz(input logic [3:0] v);
      for (int i = 0; i < 5; i++) if (tbl_in[i] == v) return int'(tbl_out[i]);
      return -1;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_full = 0; m_ptr = 0; m_id = 0; m_xyz = 0; m_cnt = 0; last_g = -1;
   endtask

   task automatic cycle(input logic [NREQ-1:0] v, input vecs_t vec, input logic rdy);
      int g;
      bit gnt;
      logic [NREQ-1:0] exp_rdy;
      bus.req_valid = v; bus.req_vec = vec; bus.rsp_ready = rdy;
      #2;
      g = -1;
      for (int k = 0; k < NREQ; k++)
         if (g < 0 && v[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
      gnt     = (m_full == 0 || rdy) && g >= 0;
      exp_rdy = gnt ? (NREQ'(1) << g) : '0;
      last_g  = gnt ? g : -1;
      chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
      @(posedge clk);
      if (gnt) begin
         m_full = 1; m_id = g; m_xyz = ref_xyz(vec[g]); m_ptr = (g + 1) % NREQ;
         if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
      end else if (m_full != 0 && rdy) begin
         m_full = 0;
      end
      #1;
      chk("rsp_valid", 32'(bus.rsp_valid), 32'(m_full));
      chk("rsp_id",    32'(bus.rsp_id),    32'(m_id));
      chk("rsp_xyz",   32'(bus.rsp_xyz),   32'(m_xyz));
`ifdef CCL_ARB_PERF_EN
      chk("perf_grants", 32'(bus.perf_grants), 32'(m_cnt));
`endif
   endtask

   initial begin
      vecs_t rr_vec, vec;
      int    gseq [5] = '{0, 1, 2, 3, 0};
      int    xseq [5] = '{4, 0, 5, 1, 4};

      tbl_in[0] = 4'b0000; tbl_out[0] = 3'b100;
      tbl_in[1] = 4'b1111; tbl_out[1] = 3'b000;
      tbl_in[2] = 4'b1000; tbl_out[2] = 3'b101;
      tbl_in[3] = 4'b0011; tbl_out[3] = 3'b001;
      tbl_in[4] = 4'b1100; tbl_out[4] = 3'b111;
      model_reset();

      // reset with all requesters valid
      bus.req_valid = '1; bus.req_vec = '0; bus.rsp_ready = 1'b1;
      #3;
      chk("rst_req_ready", 32'(bus.req_ready), 0);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
      chk("rst_rsp_xyz",   32'(bus.rsp_xyz),   0);
      chk("rst_rsp_id",    32'(bus.rsp_id),    0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_hold_req_ready", 32'(bus.req_ready), 0);
      chk("rst_hold_rsp_valid", 32'(bus.rsp_valid), 0);
`ifdef CCL_ARB_PERF_EN
      chk("rst_perf", 32'(bus.perf_grants), 0);
`endif
      @(negedge clk);
      rst_n = 1'b1;

      // round robin over all four
      rr_vec[0] = 4'b0000; rr_vec[1] = 4'b1111; rr_vec[2] = 4'b1000; rr_vec[3] = 4'b0011;
      for (int k = 0; k < 5; k++) begin
         cycle('1, rr_vec, 1'b1);
         chk("rr_grant", 32'(last_g), 32'(gseq[k]));
         chk("rr_xyz", 32'(bus.rsp_xyz), 32'(xseq[k]));
      end

      // single request on requester 0
      vec = rr_vec; vec[0] = 4'b1100;
      cycle(4'b0001, vec, 1'b1);
      chk("single_id",  32'(bus.rsp_id), 0);
      chk("single_xyz", 32'(bus.rsp_xyz), 32'(3'b111));

      // backpressure while FULL, then release
      repeat (3) begin
         cycle('1, rr_vec, 1'b0);
         chk("bp_hold_xyz", 32'(bus.rsp_xyz), 32'(3'b111));
      end
      cycle('1, rr_vec, 1'b1);
      chk("bp_release_grant", 32'(last_g), 1);

      // wrap and skip: rr_ptr=3, only req 1 valid
      cycle(4'b0100, rr_vec, 1'b1);
      cycle(4'b0010, rr_vec, 1'b1);
      chk("wrap_grant", 32'(last_g), 1);
      cycle('1, rr_vec, 1'b1);
      chk("ptr_after_wrap", 32'(last_g), 2);
      cycle('0, rr_vec, 1'b1);

      // randomized traffic
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < NREQ; i++) vec[i] = tbl_in[$urandom_range(0, 4)];
         cycle(NREQ'($urandom), vec, ($urandom_range(0, 3) != 0));
      end

      // reset mid-stream while FULL
      vec = rr_vec; vec[0] = 4'b1100;
      cycle(4'b0001, vec, 1'b1);
      cycle(4'b0001, vec, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_rsp_valid", 32'(bus.rsp_valid), 0);
      chk("midrst_rsp_xyz",   32'(bus.rsp_xyz),   0);
      chk("midrst_rsp_id",    32'(bus.rsp_id),    0);
      chk("midrst_req_ready", 32'(bus.req_ready), 0);
`ifdef CCL_ARB_PERF_EN
      chk("midrst_perf", 32'(bus.perf_grants), 0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      cycle(4'b1010, rr_vec, 1'b1);
      chk("post_rst_grant", 32'(last_g), 1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
